apb_mbox_s: RTL and testbench

APB responder (slave) that sits on one M_PSELx output of the APB interconnect and exposes a bidirectional mailbox to a local peripheral or core.
- APB writes to the data register push into a TX FIFO, which drains to a local valid/ready stream.
- A local valid/ready stream fills an RX FIFO, which APB reads of the data register pop.
- The block inserts APB wait states (PREADY low) while TX is full or RX is empty.

---
 rtl/apb_mbox_s.sv | 178 +++++++++++++++++
 tb/tb_apb_mbox_s.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/apb_mbox_s.sv
// ============================================================================
// Module   : apb_mbox_s
// Brief    : APB responder exposing a TX/RX mailbox FIFO pair with wait states.
//            Optional macro APB_MBOX_TIMEOUT_EN bounds wait states by TIMEOUT.
// Revision : 1.0
// ============================================================================
`default_nettype none

module apb_mbox_s #(
    parameter int BUS_WIDTH  = 16,
    parameter int DATA_WIDTH = 16,
    parameter int DEPTH      = 8,
    parameter int TIMEOUT    = 255
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [BUS_WIDTH-1:0]  S_PADDR,
    input  logic                  S_PWRITE,
    input  logic                  S_PSELx,
    input  logic                  S_PENABLE,
    input  logic [DATA_WIDTH-1:0] S_PWDATA,
    output logic [DATA_WIDTH-1:0] S_PRDATA,
    output logic                  S_PREADY,
    output logic                  tx_valid,
    input  logic                  tx_ready,
    output logic [DATA_WIDTH-1:0] tx_data,
    input  logic                  rx_valid,
    output logic                  rx_ready,
    input  logic [DATA_WIDTH-1:0] rx_data
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
    localparam int TIMEOUT_UNUSED = TIMEOUT;

    typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_WAIT = 1'b1} state_t;

    logic [DATA_WIDTH-1:0] tx_mem_q [DEPTH];
    logic [DATA_WIDTH-1:0] rx_mem_q [DEPTH];
    logic [PTR_W-1:0]      tx_wr_ptr_q, tx_wr_ptr_d, tx_rd_ptr_q, tx_rd_ptr_d;
    logic [PTR_W-1:0]      rx_wr_ptr_q, rx_wr_ptr_d, rx_rd_ptr_q, rx_rd_ptr_d;
    logic [CNT_W-1:0]      tx_count_q, tx_count_d, rx_count_q, rx_count_d;
    state_t                state_q, state_d;
    logic                  timeout_err_q, timeout_err_d;

    logic                  w_access, w_sel_data, w_sel_status, w_sel_ctrl;
    logic                  w_tx_wr, w_rx_rd, w_ready_raw, w_done, w_timeout;
    logic                  w_ctrl_wr, w_tx_flush, w_rx_flush, w_to_clr;
    logic                  w_tx_push, w_tx_pop, w_rx_push, w_rx_pop;
    logic [DATA_WIDTH-1:0] w_status;
    logic                  w_unused;

    assign w_unused = ^{S_PADDR[BUS_WIDTH-1:4], S_PWDATA[DATA_WIDTH-1:3]};

    assign w_access     = S_PSELx & S_PENABLE;
    assign w_sel_data   = (S_PADDR[3:0] == 4'h0);
    assign w_sel_status = (S_PADDR[3:0] == 4'h1);
    assign w_sel_ctrl   = (S_PADDR[3:0] == 4'h2);
    assign w_tx_wr      = w_access &  S_PWRITE & w_sel_data;
    assign w_rx_rd      = w_access & ~S_PWRITE & w_sel_data;

    // Readiness looks only at registered counts; same-cycle FIFO moves help next cycle.
    assign w_ready_raw = w_tx_wr ? (tx_count_q != FULL_CNT) :
                         w_rx_rd ? (rx_count_q != '0)       : w_access;
    assign w_done      = reset & w_ready_raw;

`ifdef APB_MBOX_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT + 1);
    logic [TO_W-1:0] wait_cnt_q, wait_cnt_d;

    assign w_timeout = reset & w_access & ~w_ready_raw & (state_q == ST_WAIT)
                     & (wait_cnt_q == TO_W'(TIMEOUT));
    assign wait_cnt_d = ((state_q == ST_WAIT) && (state_d == ST_WAIT)) ?
                        wait_cnt_q + TO_W'(1) : '0;

    always_ff @(posedge clk) begin
        if (!reset) wait_cnt_q <= '0;
        else        wait_cnt_q <= wait_cnt_d;
    end
`else
    assign w_timeout = 1'b0;
`endif

    assign S_PREADY   = w_done | w_timeout;
    assign w_ctrl_wr  = w_done & S_PWRITE & w_sel_ctrl;
    assign w_tx_flush = w_ctrl_wr & S_PWDATA[0];
    assign w_rx_flush = w_ctrl_wr & S_PWDATA[1];
    assign w_to_clr   = w_ctrl_wr & S_PWDATA[2];

    assign tx_valid  = reset & (tx_count_q != '0);
    assign tx_data   = tx_valid ? tx_mem_q[tx_rd_ptr_q] : '0;
    assign rx_ready  = reset & (rx_count_q != FULL_CNT) & ~w_rx_flush;

    assign w_tx_push = w_done & w_tx_wr;
    assign w_tx_pop  = tx_valid & tx_ready;
    assign w_rx_push = rx_valid & rx_ready;
    assign w_rx_pop  = w_done & w_rx_rd;

    always_comb begin
        w_status              = '0;
        w_status[0]           = (tx_count_q == FULL_CNT);
        w_status[1]           = (tx_count_q == '0);
        w_status[2]           = (rx_count_q == FULL_CNT);
        w_status[3]           = (rx_count_q == '0);
        w_status[4]           = timeout_err_q;
        w_status[8 +: CNT_W]  = rx_count_q;
    end

    always_comb begin
        S_PRDATA = '0;
        if (w_rx_pop)
            S_PRDATA = rx_mem_q[rx_rd_ptr_q];
        else if (w_done & ~S_PWRITE & w_sel_status)
            S_PRDATA = w_status;
    end

    always_comb begin
        tx_wr_ptr_d = tx_wr_ptr_q + PTR_W'(w_tx_push);
        tx_rd_ptr_d = tx_rd_ptr_q + PTR_W'(w_tx_pop);
        tx_count_d  = tx_count_q + CNT_W'(w_tx_push) - CNT_W'(w_tx_pop);
        rx_wr_ptr_d = rx_wr_ptr_q + PTR_W'(w_rx_push);
        rx_rd_ptr_d = rx_rd_ptr_q + PTR_W'(w_rx_pop);
        rx_count_d  = rx_count_q + CNT_W'(w_rx_push) - CNT_W'(w_rx_pop);
        if (w_tx_flush) begin
            tx_wr_ptr_d = '0;
            tx_rd_ptr_d = '0;
            tx_count_d  = '0;
        end
        if (w_rx_flush) begin
            rx_wr_ptr_d = '0;
            rx_rd_ptr_d = '0;
            rx_count_d  = '0;
        end

        timeout_err_d = timeout_err_q;
        if (w_timeout) timeout_err_d = 1'b1;
        if (w_to_clr)  timeout_err_d = 1'b0;

        // A dropped PSEL while waiting is a master abort back to IDLE.
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (w_access & ~S_PREADY)  state_d = ST_WAIT;
            ST_WAIT: if (S_PREADY | ~S_PSELx)   state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            tx_wr_ptr_q   <= '0;
            tx_rd_ptr_q   <= '0;
            tx_count_q    <= '0;
            rx_wr_ptr_q   <= '0;
            rx_rd_ptr_q   <= '0;
            rx_count_q    <= '0;
            timeout_err_q <= 1'b0;
            state_q       <= ST_IDLE;
        end else begin
            tx_wr_ptr_q   <= tx_wr_ptr_d;
            tx_rd_ptr_q   <= tx_rd_ptr_d;
            tx_count_q    <= tx_count_d;
            rx_wr_ptr_q   <= rx_wr_ptr_d;
            rx_rd_ptr_q   <= rx_rd_ptr_d;
            rx_count_q    <= rx_count_d;
            timeout_err_q <= timeout_err_d;
            state_q       <= state_d;
        end
    end

    always_ff @(posedge clk) begin
        if (w_tx_push) tx_mem_q[tx_wr_ptr_q] <= S_PWDATA;
        if (w_rx_push) rx_mem_q[rx_wr_ptr_q] <= rx_data;
    end

endmodule

`default_nettype wire

// File: tb/tb_apb_mbox_s.sv
// ============================================================================
// Module   : tb_apb_mbox_s
// Brief    : Randomized APB/stream traffic against a queue-based mailbox model.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_apb_mbox_s;

    localparam int BW    = 16;
    localparam int DW    = 16;
    localparam int DEPTH = 8;
    localparam int TMO   = 4;
`ifdef APB_MBOX_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic          clk, reset;
    logic [BW-1:0] paddr;
    logic          pwrite, psel, penable;
    logic [DW-1:0] pwdata, prdata;
    logic          pready;
    logic          tx_valid, tx_ready, rx_valid, rx_ready;
    logic [DW-1:0] tx_data, rx_data;

    apb_mbox_s #(
        .BUS_WIDTH (BW),
        .DATA_WIDTH(DW),
        .DEPTH     (DEPTH),
        .TIMEOUT   (TMO)
    ) u_dut (
        .clk      (clk),
        .reset    (reset),
        .S_PADDR  (paddr),
        .S_PWRITE (pwrite),
        .S_PSELx  (psel),
        .S_PENABLE(penable),
        .S_PWDATA (pwdata),
        .S_PRDATA (prdata),
        .S_PREADY (pready),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready),
        .tx_data  (tx_data),
        .rx_valid (rx_valid),
        .rx_ready (rx_ready),
        .rx_data  (rx_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s @%0t: got 0x%0h expected 0x%0h", tag, $time, got, exp);
        end
    endtask

    // Reference model state
    logic [DW-1:0] tx_q[$];
    logic [DW-1:0] rx_q[$];
    bit            terr;
    int            blocked;

    // Master state: 0 idle, 1 setup driven, 2 access driven
    int            ph;
    int            waited;
    logic [BW-1:0] m_addr;
    logic          m_wr;
    logic [DW-1:0] m_wdata;

    task automatic pick_txn();
        int r;
        logic [3:0] lo;
        r       = $urandom_range(0, 99);
        m_wdata = DW'($urandom);
        if (r < 40)      begin lo = 4'h0; m_wr = 1'b1; end
        else if (r < 70) begin lo = 4'h0; m_wr = 1'b0; end
        else if (r < 85) begin lo = 4'h1; m_wr = 1'b0; end
        else if (r < 90) begin lo = 4'h2; m_wr = 1'b1; m_wdata = DW'($urandom_range(0, 7)); end
        else begin
            lo   = 4'($urandom_range(3, 15));
            m_wr = 1'($urandom_range(0, 1));
        end
        m_addr = {12'($urandom), lo};
    endtask

    initial begin
        bit            acc, nr, fire, e_txv, e_rxr, e_rdy;
        logic [3:0]    a;
        logic [31:0]   st, e_rd, e_txd;
        int            tr_pct, rv_pct;

        reset = 1'b0; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
        paddr = '0; pwdata = '0; tx_ready = 1'b0; rx_valid = 1'b1; rx_data = '0;
        ph = 0; waited = 0; terr = 0; blocked = 0;
        m_addr = '0; m_wr = 1'b0; m_wdata = '0;

        for (int cyc = 0; cyc < 6000; cyc++) begin
            @(negedge clk);
            reset  = !(cyc < 3 || (cyc >= 3000 && cyc < 3002));
            tr_pct = ((cyc / 250) % 2) ? 85 : 10;
            rv_pct = ((cyc / 170) % 2) ? 80 : 15;
            if (cyc < 3) begin
                rx_valid = 1'b1;
                tx_ready = 1'b1;
            end else begin
                tx_ready = ($urandom_range(0, 99) < tr_pct);
                rx_valid = ($urandom_range(0, 99) < rv_pct);
            end
            rx_data = DW'($urandom);

            case (ph)
                2: if (waited >= 2 && $urandom_range(0, 15) == 0) ph = 0;
                1: ph = 2;
                default: if ($urandom_range(0, 2) != 0) begin pick_txn(); ph = 1; end
            endcase
            psel    = (ph != 0);
            penable = (ph == 2);
            paddr   = m_addr;
            pwrite  = m_wr;
            pwdata  = m_wdata;
            #1;

            acc = psel && penable;
            a   = paddr[3:0];
            st  = (32'(rx_q.size()) << 8) | (32'(terr) << 4)
                | (32'(rx_q.size() == 0) << 3) | (32'(rx_q.size() == DEPTH) << 2)
                | (32'(tx_q.size() == 0) << 1) | 32'(tx_q.size() == DEPTH);
            nr = 1'b0; fire = 1'b0; e_rd = 0;
            if (reset && acc) begin
                if (a == 4'h0 && pwrite)       nr = (tx_q.size() < DEPTH);
                else if (a == 4'h0 && !pwrite) nr = (rx_q.size() > 0);
                else                           nr = 1'b1;
                fire = TO_EN && !nr && (blocked == TMO + 1);
                if (nr && !pwrite && a == 4'h0) e_rd = 32'(rx_q[0]);
                if (nr && !pwrite && a == 4'h1) e_rd = st;
            end
            e_rdy = nr || fire;
            e_txv = reset && (tx_q.size() > 0);
            e_txd = e_txv ? 32'(tx_q[0]) : 0;
            e_rxr = reset && (rx_q.size() < DEPTH) && !(nr && pwrite && a == 4'h2 && pwdata[1]);

            check_val("pready",   32'(pready),   32'(e_rdy));
            check_val("prdata",   32'(prdata),   e_rd);
            check_val("tx_valid", 32'(tx_valid), 32'(e_txv));
            check_val("tx_data",  32'(tx_data),  e_txd);
            check_val("rx_ready", 32'(rx_ready), 32'(e_rxr));

            if (!reset) begin
                tx_q.delete(); rx_q.delete();
                terr = 0; blocked = 0; ph = 0; waited = 0;
            end else begin
                if (e_txv && tx_ready) void'(tx_q.pop_front());
                if (nr && pwrite && a == 4'h0) tx_q.push_back(pwdata);
                if (nr && !pwrite && a == 4'h0) void'(rx_q.pop_front());
                if (rx_valid && e_rxr) rx_q.push_back(rx_data);
                if (nr && pwrite && a == 4'h2) begin
                    if (pwdata[0]) tx_q.delete();
                    if (pwdata[1]) rx_q.delete();
                    if (pwdata[2]) terr = 0;
                end
                if (fire) terr = 1;
                blocked = (acc && !e_rdy) ? blocked + 1 : 0;
                if (ph == 2) begin
                    if (e_rdy) begin ph = 0; waited = 0; end
                    else waited++;
                end
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
